mult_pipe: RTL and testbench

//  Parametrised pipelined integer multiplier FU for the RV32M/RV64M MUL* group with a

---
 rtl/mult_pkg.sv | 28 ++
 rtl/mult_pipe_stage.sv | 55 +++++
 rtl/mult_pipe.sv | 126 ++++++++++++
 tb/tb_mult_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and configuration for the pipelined MUL* functional unit.
// The stage struct is sized from these localparams, so mult_pipe must be built with matching parameters.
package mult_pkg;

    localparam int MULT_XLEN      = 32;
    localparam int MULT_STAGES    = 4;
    localparam int MULT_TAG_W     = 6;
    localparam int MULT_BMASK_W   = 4;
    localparam int BITS_PER_STAGE = (2 * MULT_XLEN) / MULT_STAGES;

    typedef enum logic [2:0] {
        FUNC_MUL    = 3'b000,
        FUNC_MULH   = 3'b001,
        FUNC_MULHSU = 3'b010,
        FUNC_MULHU  = 3'b011
    } MULT_FUNC;

    typedef struct packed {
        logic                    valid;
        MULT_FUNC                func;
        logic [MULT_TAG_W-1:0]   tag;
        logic [MULT_BMASK_W-1:0] bmask;
        logic [2*MULT_XLEN-1:0]  sum;
        logic [2*MULT_XLEN-1:0]  mplier;
        logic [2*MULT_XLEN-1:0]  mcand;
    } MULT_STAGE_T;

endpackage

// File: rtl/mult_pipe_stage.sv
// One multiplier pipeline stage: adds BITS_PER_STAGE multiplier bits times the multiplicand
// to the running sum, with an async-reset valid bit and resolve-updated branch mask.
module mult_pipe_stage
    import mult_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    advance_in,
    input  logic                    kill_in,
    input  logic [MULT_BMASK_W-1:0] clear_mask,
    input  MULT_STAGE_T             prev,
    output MULT_STAGE_T             cur
);

    localparam int PW = 2 * MULT_XLEN;

    logic                    vld_p;
    MULT_FUNC                func_p;
    logic [MULT_TAG_W-1:0]   tag_p;
    logic [MULT_BMASK_W-1:0] bmask_p;
    logic [PW-1:0]           sum_p;
    logic [PW-1:0]           mplier_p;
    logic [PW-1:0]           mcand_p;
    logic [PW-1:0]           partial;

    assign partial = {{(PW - BITS_PER_STAGE){1'b0}}, prev.mplier[BITS_PER_STAGE-1:0]} * prev.mcand;

    // kill_in already refers to whichever op this stage will hold after the edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p <= 1'b0;
        end else if (advance_in) begin
            vld_p <= prev.valid && !kill_in;
        end else begin
            vld_p <= vld_p && !kill_in;
        end
    end

    always_ff @(posedge clock) begin
        if (advance_in) begin
            func_p   <= prev.func;
            tag_p    <= prev.tag;
            bmask_p  <= prev.bmask & ~clear_mask;
            sum_p    <= prev.sum + partial;
            mplier_p <= prev.mplier >> BITS_PER_STAGE;
            mcand_p  <= prev.mcand << BITS_PER_STAGE;
        end else begin
            bmask_p  <= bmask_p & ~clear_mask;
        end
    end

    assign cur = '{valid: vld_p, func: func_p, tag: tag_p, bmask: bmask_p,
                   sum: sum_p, mplier: mplier_p, mcand: mcand_p};

endmodule

// File: rtl/mult_pipe.sv
// Pipelined RV32M/RV64M MUL* unit with valid/ready handshake, tag passthrough and branch squash/resolve.
// Define MULT_PIPE_BUBBLE_COLLAPSE_EN for per-stage advance that compresses bubbles behind a stalled head.
module mult_pipe
    import mult_pkg::*;
#(
    parameter int XLEN    = MULT_XLEN,
    parameter int STAGES  = MULT_STAGES,
    parameter int TAG_W   = MULT_TAG_W,
    parameter int BMASK_W = MULT_BMASK_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_func,
    input  logic [XLEN-1:0]    in_rs1,
    input  logic [XLEN-1:0]    in_rs2,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [BMASK_W-1:0] in_bmask,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_result,
    output logic [TAG_W-1:0]   out_tag,
    output logic [BMASK_W-1:0] out_bmask,
    input  logic               squash_valid,
    input  logic [BMASK_W-1:0] squash_mask,
    input  logic               resolve_valid,
    input  logic [BMASK_W-1:0] resolve_mask,
    output logic               busy
);

    localparam int PW = 2 * XLEN;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("mult_pipe: XLEN must be 32 or 64");
    end
    if ((PW % STAGES) != 0) begin : g_bad_stages
        $error("mult_pipe: 2*XLEN must be divisible by STAGES");
    end
    if (XLEN != MULT_XLEN || STAGES != MULT_STAGES || TAG_W != MULT_TAG_W || BMASK_W != MULT_BMASK_W) begin : g_bad_cfg
        $error("mult_pipe: parameters must match the mult_pkg configuration");
    end

    function automatic logic [PW-1:0] extend(input logic [XLEN-1:0] val, input logic is_signed);
        return {{XLEN{is_signed & val[XLEN-1]}}, val};
    endfunction

    function automatic logic [XLEN-1:0] select_slice(input MULT_FUNC f, input logic [PW-1:0] prod);
        return (f == FUNC_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
    endfunction

    MULT_FUNC           func;
    MULT_STAGE_T        issue_op;
    MULT_STAGE_T        stage_p [STAGES];
    MULT_STAGE_T        head;
    logic [STAGES-1:0]  take;
    logic [STAGES-1:0]  kill;
    logic [STAGES-1:0]  vld_p;
    logic [BMASK_W-1:0] clear_mask;
    logic               unused_head;

    always_comb begin
        func            = MULT_FUNC'(in_func);
        issue_op.valid  = in_valid;
        issue_op.func   = func;
        issue_op.tag    = in_tag;
        issue_op.bmask  = in_bmask;
        issue_op.sum    = '0;
        issue_op.mcand  = extend(in_rs1, func != FUNC_MULHU);
        issue_op.mplier = extend(in_rs2, func == FUNC_MUL || func == FUNC_MULH);
    end

    assign clear_mask = resolve_valid ? resolve_mask : '0;

    // stage i loads from stage i-1 (stage 0 from the issue port) whenever take[i] is set
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        MULT_STAGE_T prev;
        if (i == 0) begin : g_first
            assign prev = issue_op;
        end else begin : g_rest
            assign prev = stage_p[i-1];
        end

        assign kill[i]  = squash_valid && |((take[i] ? prev.bmask : stage_p[i].bmask) & squash_mask);
        assign vld_p[i] = stage_p[i].valid;

        mult_pipe_stage u_stage (
            .clock      (clock),
            .reset      (reset),
            .advance_in (take[i]),
            .kill_in    (kill[i]),
            .clear_mask (clear_mask),
            .prev       (prev),
            .cur        (stage_p[i])
        );
    end

    // output boundary: a squashed head drops out combinationally and never blocks
    assign head        = stage_p[STAGES-1];
    assign out_valid   = head.valid && !(squash_valid && |(head.bmask & squash_mask));
    assign out_result  = select_slice(head.func, head.sum);
    assign out_tag     = head.tag;
    assign out_bmask   = head.bmask & ~clear_mask;
    assign unused_head = ^{head.mplier, head.mcand};

`ifdef MULT_PIPE_BUBBLE_COLLAPSE_EN
    always_comb begin
        take[STAGES-1] = !out_valid || out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            take[i] = !stage_p[i].valid || take[i+1];
        end
    end
`else
    logic advance;
    assign advance = !(out_valid && !out_ready);
    assign take    = {STAGES{advance}};
`endif

    assign in_ready = take[0];
    assign busy     = |vld_p;

    assert property (@(posedge clock) disable iff (reset)
        !(squash_valid && resolve_valid && |(squash_mask & resolve_mask)))
        else $error("mult_pipe: squash and resolve of the same branch in one cycle");

endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe at XLEN=32, STAGES=4; stall-ready expectations follow
// MULT_PIPE_BUBBLE_COLLAPSE_EN when it is defined.
module tb_mult_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_func;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [5:0]  in_tag;
    logic [3:0]  in_bmask;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [5:0]  out_tag;
    logic [3:0]  out_bmask;
    logic        squash_valid;
    logic [3:0]  squash_mask;
    logic        resolve_valid;
    logic [3:0]  resolve_mask;
    logic        busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [2:0]  stall_rdy;
    logic        took;

    mult_pipe dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_func       (in_func),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_tag        (in_tag),
        .in_bmask      (in_bmask),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_tag       (out_tag),
        .out_bmask     (out_bmask),
        .squash_valid  (squash_valid),
        .squash_mask   (squash_mask),
        .resolve_valid (resolve_valid),
        .resolve_mask  (resolve_mask),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag, input logic [3:0] bm);
        in_valid = 1'b1;
        in_func  = f;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        in_bmask = bm;
    endtask

    task automatic wait_out(input string name);
        for (int n = 0; n < 8 && !out_valid; n++) step();
        check({name, "_vld"}, 64'(out_valid), 64'd1);
    endtask

    task automatic expect_out(input string name, input logic [63:0] res, input logic [5:0] tag,
                              input logic [3:0] bm);
        wait_out(name);
        check({name, "_res"}, 64'(out_result), res);
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
        check({name, "_bmask"}, 64'(out_bmask), 64'(bm));
        step();
    endtask

    task automatic run_latency(input string name, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [5:0] tag, input logic [63:0] res);
        out_ready = 1'b1;
        drive(f, a, b, tag, 4'b0000);
        #1;
        check({name, "_accept"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        step();
        step();
        check({name, "_early"}, 64'(out_valid), 64'd0);
        step();
        check({name, "_vld"}, 64'(out_valid), 64'd1);
        check({name, "_res"}, 64'(out_result), res);
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef MULT_PIPE_BUBBLE_COLLAPSE_EN
        stall_rdy = 3'b001;
`else
        stall_rdy = 3'b000;
`endif
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_func       = 3'b000;
        in_rs1        = '0;
        in_rs2        = '0;
        in_tag        = '0;
        in_bmask      = '0;
        out_ready     = 1'b1;
        squash_valid  = 1'b0;
        squash_mask   = '0;
        resolve_valid = 1'b0;
        resolve_mask  = '0;
        took          = 1'b0;

        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        step();
        reset = 1'b0;
        step();

        // MUL -1 x 5 with exact latency
        run_latency("t1_mul", 3'b000, 32'hFFFF_FFFF, 32'd5, 6'h2A, 64'hFFFF_FFFB);

        // high-half variants on all-ones operands
        drive(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h01, 4'b0000);
        step();
        drive(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h02, 4'b0000);
        step();
        drive(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h03, 4'b0000);
        step();
        in_valid = 1'b0;
        expect_out("t2_mulh", 64'h0000_0000, 6'h01, 4'b0000);
        expect_out("t2_mulhu", 64'hFFFF_FFFE, 6'h02, 4'b0000);
        expect_out("t2_mulhsu", 64'hFFFF_FFFF, 6'h03, 4'b0000);

        // eight back-to-back ops, one result per cycle
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                drive(3'b000, 32'(c), 32'(c + 1), 6'(c), 4'b0000);
                #1;
                check("t3_in_ready", 64'(in_ready), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (c >= 3) begin
                check("t3_vld", 64'(out_valid), 64'd1);
                check("t3_res", 64'(out_result), 64'((c - 3) * (c - 2)));
                check("t3_tag", 64'(out_tag), 64'(c - 3));
            end
        end
        step();
        check("t3_drained_vld", 64'(out_valid), 64'd0);
        check("t3_drained_busy", 64'(busy), 64'd0);

        // stall with a bubble at stage 1
        drive(3'b000, 32'd3, 32'd4, 6'h11, 4'b0000);
        step();
        drive(3'b000, 32'd5, 32'd6, 6'h12, 4'b0000);
        step();
        in_valid = 1'b0;
        step();
        drive(3'b000, 32'd7, 32'd8, 6'h13, 4'b0000);
        step();
        out_ready = 1'b0;
        drive(3'b000, 32'd9, 32'd10, 6'h14, 4'b0000);
        for (int j = 0; j < 3; j++) begin
            #1;
            check("t4_hold_vld", 64'(out_valid), 64'd1);
            check("t4_hold_res", 64'(out_result), 64'd12);
            check("t4_hold_tag", 64'(out_tag), 64'h11);
            check("t4_in_ready", 64'(in_ready), 64'(stall_rdy[j]));
            took = in_valid && in_ready;
            step();
            if (took) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        #1;
        check("t4_release_rdy", 64'(in_ready), 64'd1);
        check("t4_a_res", 64'(out_result), 64'd12);
        check("t4_a_tag", 64'(out_tag), 64'h11);
        step();
        in_valid = 1'b0;
        expect_out("t4_b", 64'd30, 6'h12, 4'b0000);
        expect_out("t4_c", 64'd56, 6'h13, 4'b0000);
        expect_out("t4_d", 64'd90, 6'h14, 4'b0000);
        check("t4_idle", 64'(busy), 64'd0);

        // squash branch 0010, then resolve branch 0100 on the head
        drive(3'b000, 32'd2, 32'd3, 6'h01, 4'b0010);
        step();
        drive(3'b000, 32'd4, 32'd5, 6'h02, 4'b0100);
        step();
        drive(3'b000, 32'd1, 32'd1, 6'h03, 4'b0010);
        step();
        drive(3'b000, 32'd6, 32'd7, 6'h04, 4'b0100);
        step();
        squash_valid = 1'b1;
        squash_mask  = 4'b0010;
        drive(3'b000, 32'd9, 32'd9, 6'h05, 4'b0010);
        #1;
        check("t5_head_squashed", 64'(out_valid), 64'd0);
        check("t5_in_ready", 64'(in_ready), 64'd1);
        check("t5_busy", 64'(busy), 64'd1);
        step();
        squash_valid = 1'b0;
        in_valid     = 1'b0;
        expect_out("t5_op2", 64'd20, 6'h02, 4'b0100);
        wait_out("t5_op4");
        check("t5_op4_bmask_pre", 64'(out_bmask), 64'h4);
        resolve_valid = 1'b1;
        resolve_mask  = 4'b0100;
        #1;
        check("t5_op4_bmask_resolved", 64'(out_bmask), 64'h0);
        check("t5_op4_res", 64'(out_result), 64'd42);
        check("t5_op4_tag", 64'(out_tag), 64'h04);
        step();
        resolve_valid = 1'b0;
        check("t5_idle_vld", 64'(out_valid), 64'd0);
        check("t5_idle_busy", 64'(busy), 64'd0);

        // asynchronous reset with three ops in flight
        out_ready = 1'b0;
        drive(3'b000, 32'd1, 32'd1, 6'h21, 4'b0000);
        step();
        drive(3'b000, 32'd2, 32'd2, 6'h22, 4'b0000);
        step();
        drive(3'b000, 32'd3, 32'd3, 6'h23, 4'b0000);
        step();
        in_valid = 1'b0;
        step();
        check("t6_pre_vld", 64'(out_valid), 64'd1);
        check("t6_pre_busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_vld", 64'(out_valid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock);
        #3;
        reset = 1'b0;
        run_latency("t6_after", 3'b000, 32'd7, 32'd6, 6'h33, 64'd42);
        check("t6_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
